// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with iterative MULT/DIV into HI/LO, start/ready/done handshake (rev 1.0).
// Optional ALU_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.
`timescale 1ns/1ps
`default_nettype none

module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] aluresult,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MULT  = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;
   localparam logic [3:0] OP_DIV   = 4'b1011;
   localparam logic [3:0] OP_MFHI  = 4'b1101;
   localparam logic [3:0] OP_MFLO  = 4'b1110;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EXEC = 3'd1,
      S_MUL  = 3'd2,
      S_DIV  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fin_q, fin_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             divz_q, divz_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             w_is_mul, w_is_div, w_signed, w_sa, w_sb;
   logic [WIDTH-1:0] w_mag_a, w_mag_b;
   logic [WIDTH-1:0] w_add, w_sub, w_res1;
   logic [WIDTH:0]   w_sum, w_rem_sh, w_diff;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH-1:0] w_quo_fix, w_rem_fix;
   logic [CW-1:0]    w_cnt_next;

   assign w_is_mul = (operation == OP_MULTU) || (operation == OP_MULT);
   assign w_is_div = (operation == OP_DIVU)  || (operation == OP_DIV);
   assign w_signed = (operation == OP_MULT)  || (operation == OP_DIV);
   assign w_sa     = w_signed & data_a[WIDTH-1];
   assign w_sb     = w_signed & data_b[WIDTH-1];
   assign w_mag_a  = w_sa ? -data_a : data_a;
   assign w_mag_b  = w_sb ? -data_b : data_b;

   assign w_add = a_q + b_q;
   assign w_sub = a_q - b_q;

   always_comb begin
      w_res1 = '0;
      case (op_q)
         OP_AND:  w_res1 = a_q & b_q;
         OP_OR:   w_res1 = a_q | b_q;
         OP_ADD:  w_res1 = w_add;
         OP_SUB:  w_res1 = w_sub;
         OP_SLT:  w_res1 = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_NOR:  w_res1 = ~(a_q | b_q);
         OP_MFHI: w_res1 = hi_q;
         OP_MFLO: w_res1 = lo_q;
         default: w_res1 = '0;
      endcase
   end

   // Multiply: acc holds the running upper half, a_q shifts the multiplier out / product in.
   assign w_sum      = {1'b0, acc_q} + (a_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
   // Divide: acc holds the partial remainder, a_q shifts the dividend out / quotient in.
   assign w_rem_sh   = {acc_q, a_q[WIDTH-1]};
   assign w_diff     = w_rem_sh - {1'b0, b_q};
   assign w_prod     = {acc_q, a_q};
   assign w_prod_fix = neg_q ? -w_prod : w_prod;
   assign w_quo_fix  = divz_q ? '1 : (neg_q ? -a_q : a_q);
   assign w_rem_fix  = rneg_q ? -acc_q : acc_q;
   assign w_cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fin_d   = fin_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      divz_d  = divz_q;
      res_d   = res_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = operation;
               cnt_d  = '0;
               fin_d  = 1'b0;
               acc_d  = '0;
               divz_d = (data_b == '0);
               if (w_is_mul || w_is_div) begin
                  a_d     = w_mag_a;
                  b_d     = w_mag_b;
                  neg_d   = w_sa ^ w_sb;
                  rneg_d  = w_sa;
                  state_d = w_is_mul ? S_MUL : S_DIV;
               end else begin
                  a_d     = data_a;
                  b_d     = data_b;
                  neg_d   = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            res_d   = w_res1;
            state_d = S_DONE;
         end
         S_MUL: begin
            if (fin_q) begin
               hi_d    = w_prod_fix[2*WIDTH-1:WIDTH];
               lo_d    = w_prod_fix[WIDTH-1:0];
               res_d   = w_prod_fix[WIDTH-1:0];
               fin_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               acc_d = w_sum[WIDTH:1];
               a_d   = {w_sum[0], a_q[WIDTH-1:1]};
               cnt_d = w_cnt_next;
               fin_d = (cnt_q == CNT_LAST);
            end
         end
         S_DIV: begin
            if (fin_q) begin
               hi_d    = w_rem_fix;
               lo_d    = w_quo_fix;
               res_d   = w_quo_fix;
               fin_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               if (!w_diff[WIDTH]) begin
                  acc_d = w_diff[WIDTH-1:0];
                  a_d   = {a_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = w_rem_sh[WIDTH-1:0];
                  a_d   = {a_q[WIDTH-2:0], 1'b0};
               end
               cnt_d = w_cnt_next;
               fin_d = (cnt_q == CNT_LAST);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         divz_q  <= 1'b0;
         res_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fin_q   <= fin_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         divz_q  <= divz_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE);
   assign aluresult = res_q;
   assign zero      = (res_q == '0);
   assign hi        = hi_q;
   assign lo        = lo_q;

`ifdef ALU_OVERFLOW_EN
   logic ovf_q;
   logic w_ovf;

   always_comb begin
      w_ovf = 1'b0;
      case (op_q)
         OP_ADD:  w_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_add[WIDTH-1] != a_q[WIDTH-1]);
         OP_SUB:  w_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (w_sub[WIDTH-1] != a_q[WIDTH-1]);
         default: w_ovf = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (state_q == S_EXEC) begin
         ovf_q <= w_ovf;
      end else if (((state_q == S_MUL) || (state_q == S_DIV)) && fin_q) begin
         ovf_q <= 1'b0;
      end
   end

   assign overflow = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for alu_multicycle with directed, hand-computed vectors.
`timescale 1ns/1ps
`default_nettype none

module tb_alu_multicycle;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    operation = 4'b0;
   logic [W-1:0]  data_a = '0;
   logic [W-1:0]  data_b = '0;
   logic          ready, done, zero;
   logic [W-1:0]  aluresult, hi, lo;
`ifdef ALU_OVERFLOW_EN
   logic          overflow;
`endif

   alu_multicycle #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .data_a(data_a), .data_b(data_b), .ready(ready), .done(done),
      .aluresult(aluresult), .zero(zero), .hi(hi), .lo(lo)
`ifdef ALU_OVERFLOW_EN
      , .overflow(overflow)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        ovf;
      int          cyc;
      string       name;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, want);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
         end else begin
            mon_e = sbq.pop_front();
            chk({mon_e.name, "/res"},  aluresult, mon_e.res);
            chk({mon_e.name, "/zero"}, {31'b0, zero}, {31'b0, (mon_e.res == 32'h0)});
            chk({mon_e.name, "/hi"},   hi, mon_e.hi);
            chk({mon_e.name, "/lo"},   lo, mon_e.lo);
            chk({mon_e.name, "/cycle"}, cyc, mon_e.cyc);
`ifdef ALU_OVERFLOW_EN
            chk({mon_e.name, "/ovf"},  {31'b0, overflow}, {31'b0, mon_e.ovf});
`endif
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [31:0] h, input logic [31:0] l,
                        input logic ov, input int lat, input string nm, input bit push);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL %s/ready_wait: got ready=0 expected ready=1 within 200 cycles", nm);
      end
      start = 1'b1; operation = op; data_a = a; data_b = b;
      @(posedge clk);
      #1;
      start = 1'b0; operation = 4'($urandom); data_a = $urandom; data_b = $urandom;
      if (push) begin
         e.res = res; e.hi = h; e.lo = l; e.ovf = ov; e.cyc = cyc + lat; e.name = nm;
         sbq.push_back(e);
      end
   endtask

   task automatic op1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic ov, input string nm);
      issue(op, a, b, res, hi_m, lo_m, ov, 1, nm, 1'b1);
   endtask

   task automatic opm(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] h, input logic [31:0] l, input string nm);
      hi_m = h;
      lo_m = l;
      issue(op, a, b, l, h, l, 1'b0, 33, nm, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("rst/ready", {31'b0, ready}, 32'd1);
      chk("rst/done",  {31'b0, done},  32'd0);
      chk("rst/res",   aluresult, 32'h0);
      chk("rst/zero",  {31'b0, zero},  32'd1);
      chk("rst/hi",    hi, 32'h0);
      chk("rst/lo",    lo, 32'h0);
      reset = 1'b0;

      op1(4'b0000, 32'h0000A5A5, 32'h000000FF, 32'h000000A5, 1'b0, "AND");
      op1(4'b0001, 32'h0000A5A5, 32'h000000FF, 32'h0000A5FF, 1'b0, "OR");
      op1(4'b1100, 32'h0000A5A5, 32'h000000FF, 32'hFFFF5A00, 1'b0, "NOR");
      op1(4'b0010, 32'd7, 32'd35, 32'd42, 1'b0, "ADD");
      op1(4'b0110, 32'd7, 32'd35, 32'hFFFFFFE4, 1'b0, "SUB");
      op1(4'b0111, 32'd7, 32'd35, 32'd1, 1'b0, "SLT_lt");
      op1(4'b0111, 32'd42, 32'd35, 32'd0, 1'b0, "SLT_ge");
      op1(4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, "SLT_neg");
      op1(4'b0011, 32'h12345678, 32'h1, 32'd0, 1'b0, "UNDEF");
      op1(4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, "ADD_ovf");
      op1(4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, "SUB_ovf");
      op1(4'b0010, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0, "ADD_wrap");

      opm(4'b1001, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "MULT");
      repeat (5) @(negedge clk);
      chk("MULT/busy_ready", {31'b0, ready}, 32'd0);
      start = 1'b1; operation = 4'b0010; data_a = 32'd1; data_b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1; operation = 4'b0010;
      @(posedge clk);
      #1;
      start = 1'b0;

      op1(4'b1101, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, "MFHI");
      op1(4'b1110, 32'h0, 32'h0, 32'hFFFFFFF1, 1'b0, "MFLO");
      opm(4'b1011, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "DIV_neg");
      opm(4'b1010, 32'd9, 32'd0, 32'h00000009, 32'hFFFFFFFF, "DIVU_zero");
      opm(4'b1011, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "DIV_ovf");
      opm(4'b1011, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "DIV_negb");
      opm(4'b1010, 32'd100, 32'd7, 32'd2, 32'd14, "DIVU");
      opm(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "MULTU_max");
      op1(4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, "ADD_pre");

      issue(4'b1000, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 1'b0, 0, "MULTU_abort", 1'b0);
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort/ready", {31'b0, ready}, 32'd1);
      chk("abort/done",  {31'b0, done},  32'd0);
      chk("abort/res",   aluresult, 32'h0);
      chk("abort/zero",  {31'b0, zero},  32'd1);
      chk("abort/hi",    hi, 32'h0);
      chk("abort/lo",    lo, 32'h0);
      hi_m = '0;
      lo_m = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);

      op1(4'b1101, 32'h0, 32'h0, 32'h0, 1'b0, "MFHI_post");
      op1(4'b0110, 32'd50, 32'd8, 32'd42, 1'b0, "SUB_post");

      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("drain/outstanding", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
